// File: rtl/lsu_mem_ctrl.sv
// Load/store access unit: one request at a time on a synchronous memory handshake.
// Define LSU_TIMEOUT_EN to add a WAIT-state watchdog that ends a hung access with err.
module lsu_mem_ctrl #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] Store_in,
  output logic              req_ready,
  output logic [DATA_W-1:0] Load_in,
  output logic              load_valid,
  output logic              op_done,
  output logic              err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t state;
  logic   op_we;

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  logic [CNT_W-1:0] wait_cnt;
`else
  assign err = 1'b0;
  // TIMEOUT only sizes the watchdog; keep it referenced when the watchdog is compiled out.
  if (TIMEOUT == 0) begin : g_timeout_unused
  end
`endif

  // mem_addr/mem_wdata double as the latched request; mem_we is cleared in DONE, so op_we keeps the kind.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      op_we      <= 1'b0;
      req_ready  <= 1'b1;
      Load_in    <= '0;
      load_valid <= 1'b0;
      op_done    <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
`ifdef LSU_TIMEOUT_EN
      wait_cnt   <= '0;
      err        <= 1'b0;
`endif
    end else begin
      mem_en     <= 1'b0;
      op_done    <= 1'b0;
      load_valid <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      err        <= 1'b0;
`endif
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            op_we     <= req_we;
            mem_we    <= req_we;
            mem_addr  <= req_addr;
            mem_wdata <= Store_in;
            mem_en    <= 1'b1;
            req_ready <= 1'b0;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE, S_WAIT: begin
          if (mem_ack) begin
            state      <= S_DONE;
            mem_we     <= 1'b0;
            op_done    <= 1'b1;
            load_valid <= !op_we;
            if (!op_we) Load_in <= mem_rdata;
          end else if (state == S_ISSUE) begin
            state <= S_WAIT;
`ifdef LSU_TIMEOUT_EN
            wait_cnt <= '0;
          end else if (wait_cnt == CNT_LAST) begin
            state      <= S_DONE;
            mem_we     <= 1'b0;
            op_done    <= 1'b1;
            err        <= 1'b1;
            load_valid <= !op_we;
            if (!op_we) Load_in <= '1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
`endif
          end
        end
        S_DONE: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: directed scenarios plus randomized
// transactions compared against a transaction-level model of the unit.
module tb_lsu_mem_ctrl;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] Store_in;
  logic              req_ready;
  logic [DATA_W-1:0] Load_in;
  logic              load_valid;
  logic              op_done;
  logic              err;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  int checks = 0;
  int errors = 0;

  // Model: the word the register file should currently see on Load_in.
  logic [DATA_W-1:0] exp_load;

  // Observations of the most recent run_txn.
  int                o_issue, o_done, o_ready, o_en_cnt, o_lv_cnt, o_done_cnt, o_err_cnt;
  logic              o_en_we;
  logic [ADDR_W-1:0] o_en_addr;
  logic [DATA_W-1:0] o_en_wdata;
  logic [DATA_W-1:0] o_load_done;

  lsu_mem_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .Store_in(Store_in), .req_ready(req_ready), .Load_in(Load_in), .load_valid(load_valid),
    .op_done(op_done), .err(err), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  // Drives one request from IDLE and records what the unit does. Cycle c counts
  // negedges after the accepting edge. waits < 0 means memory never acks.
  task automatic run_txn(input logic we, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] wdata, input int waits,
                         input logic [DATA_W-1:0] rdata, input logic stray_done);
    int c;
    c = 0;
    o_issue = -1; o_done = -1; o_ready = -1;
    o_en_cnt = 0; o_lv_cnt = 0; o_done_cnt = 0; o_err_cnt = 0;
    o_en_we = 1'bx; o_en_addr = 'x; o_en_wdata = 'x; o_load_done = 'x;
    req_valid = 1'b1; req_we = we; req_addr = addr; Store_in = wdata; mem_ack = 1'b0;
    while (c < 80) begin
      @(posedge clk);
      @(negedge clk);
      c++;
      mem_ack = 1'b0;
      if (c == 1) begin
        req_valid = 1'b0;
        req_we    = 1'($urandom_range(0, 1));
        req_addr  = ADDR_W'($urandom);
        Store_in  = DATA_W'($urandom);
      end
      if (mem_en) begin
        o_en_cnt++; o_issue = c;
        o_en_we = mem_we; o_en_addr = mem_addr; o_en_wdata = mem_wdata;
      end
      if (load_valid) o_lv_cnt++;
      if (err) o_err_cnt++;
      if (op_done) begin
        o_done_cnt++; o_done = c; o_load_done = Load_in;
        if (stray_done) begin
          mem_ack = 1'b1; mem_rdata = ~rdata;
        end
      end
      if (req_ready && c > 1) begin
        o_ready = c;
        break;
      end
      if (waits >= 0 && c == 1 + waits) begin
        mem_ack = 1'b1; mem_rdata = rdata;
      end
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; Store_in = '0;
    mem_rdata = '0; mem_ack = 1'b0; exp_load = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({req_ready, op_done, load_valid, mem_en, mem_we, err} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 100000", {req_ready, op_done, load_valid, mem_en, mem_we, err});
    end
    checks++;
    if (Load_in !== exp_load) begin
      errors++; $display("FAIL reset_load_in: got %h expected %h", Load_in, exp_load);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || mem_en !== 1'b0) begin
      errors++; $display("FAIL reset_release_idle: got ready=%b en=%b expected ready=1 en=0", req_ready, mem_en);
    end
  endtask

  task automatic test_store_zero_wait();
    run_txn(1'b1, 8'h02, 16'h1234, 0, 16'hDEAD, 1'b0);
    checks++;
    if (o_en_cnt !== 1 || o_issue !== 1) begin
      errors++; $display("FAIL store_strobe: got count=%0d at=%0d expected count=1 at=1", o_en_cnt, o_issue);
    end
    checks++;
    if ({o_en_we, o_en_addr, o_en_wdata} !== {1'b1, 8'h02, 16'h1234}) begin
      errors++; $display("FAIL store_bus: got we=%b addr=%h wdata=%h expected we=1 addr=02 wdata=1234", o_en_we, o_en_addr, o_en_wdata);
    end
    checks++;
    if (o_done !== 2 || o_done_cnt !== 1 || o_ready !== 3) begin
      errors++; $display("FAIL store_latency: got done=%0d x%0d ready=%0d expected done=2 x1 ready=3", o_done, o_done_cnt, o_ready);
    end
    checks++;
    if (o_lv_cnt !== 0 || Load_in !== exp_load) begin
      errors++; $display("FAIL store_no_load: got lv=%0d load_in=%h expected lv=0 load_in=%h", o_lv_cnt, Load_in, exp_load);
    end
  endtask

  task automatic test_load_wait3();
    run_txn(1'b0, 8'h05, 16'h0000, 3, 16'hBEEF, 1'b0);
    exp_load = 16'hBEEF;
    checks++;
    if (o_en_cnt !== 1 || o_en_we !== 1'b0 || o_en_addr !== 8'h05) begin
      errors++; $display("FAIL load_bus: got count=%0d we=%b addr=%h expected count=1 we=0 addr=05", o_en_cnt, o_en_we, o_en_addr);
    end
    checks++;
    if (o_done !== 5 || o_ready !== 6 || o_done_cnt !== 1) begin
      errors++; $display("FAIL load_latency: got done=%0d x%0d ready=%0d expected done=5 x1 ready=6", o_done, o_done_cnt, o_ready);
    end
    checks++;
    if (o_lv_cnt !== 1 || o_load_done !== exp_load || Load_in !== exp_load) begin
      errors++; $display("FAIL load_data: got lv=%0d at_done=%h now=%h expected lv=1 data=%h", o_lv_cnt, o_load_done, Load_in, exp_load);
    end
  endtask

  task automatic test_reset_mid_wait();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h05; Store_in = '0;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    #2 rst = 1'b0;
    #1;
    exp_load = '0;
    checks++;
    if (req_ready !== 1'b1 || mem_en !== 1'b0 || Load_in !== exp_load) begin
      errors++; $display("FAIL reset_async: got ready=%b en=%b load_in=%h expected ready=1 en=0 load_in=0000", req_ready, mem_en, Load_in);
    end
    mem_ack = 1'b1; mem_rdata = 16'h7777;
    @(posedge clk); @(negedge clk);
    rst = 1'b1; mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({req_ready, op_done, load_valid, mem_en, err} !== 5'b10000 || Load_in !== exp_load) begin
        errors++; $display("FAIL reset_abort_c%0d: got ctrl=%b load_in=%h expected ctrl=10000 load_in=%h", i, {req_ready, op_done, load_valid, mem_en, err}, Load_in, exp_load);
      end
    end
  endtask

  task automatic test_busy();
    int en_cnt, busy_bad;
    logic [ADDR_W-1:0] second_addr;
    logic second_we;
    int second_at;
    en_cnt = 0; busy_bad = 0; second_at = -1; second_addr = '0; second_we = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h05; Store_in = '0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); @(negedge clk);
      mem_ack = 1'b0;
      if (c == 1) req_valid = 1'b0;
      if (mem_en) begin
        en_cnt++;
        if (c > 1) begin second_at = c; second_addr = mem_addr; second_we = mem_we; end
      end
      if (c >= 2 && c <= 4 && req_ready !== 1'b0) busy_bad++;
      if (c == 2) begin req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h07; Store_in = 16'hA5A5; end
      if (c == 3) begin mem_ack = 1'b1; mem_rdata = 16'h1111; end
      if (c == 6) begin req_valid = 1'b0; mem_ack = 1'b1; end
    end
    exp_load = 16'h1111;
    checks++;
    if (busy_bad !== 0) begin
      errors++; $display("FAIL busy_ready: got %0d busy cycles with ready=1 expected 0", busy_bad);
    end
    checks++;
    if (en_cnt !== 2 || second_at !== 6) begin
      errors++; $display("FAIL busy_issue: got strobes=%0d second_at=%0d expected strobes=2 second_at=6", en_cnt, second_at);
    end
    checks++;
    if (second_addr !== 8'h07 || second_we !== 1'b1 || Load_in !== exp_load) begin
      errors++; $display("FAIL busy_second: got addr=%h we=%b load_in=%h expected addr=07 we=1 load_in=%h", second_addr, second_we, Load_in, exp_load);
    end
  endtask

  task automatic test_stray_ack();
    mem_ack = 1'b1; mem_rdata = 16'h5555; req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({req_ready, op_done, load_valid, mem_en, err} !== 5'b10000 || Load_in !== exp_load) begin
        errors++; $display("FAIL stray_ack_c%0d: got ctrl=%b load_in=%h expected ctrl=10000 load_in=%h", i, {req_ready, op_done, load_valid, mem_en, err}, Load_in, exp_load);
      end
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_timeout();
`ifdef LSU_TIMEOUT_EN
    run_txn(1'b0, 8'h09, 16'h0000, -1, 16'h0000, 1'b0);
    exp_load = '1;
    checks++;
    if (o_done !== TIMEOUT + 2 || o_ready !== TIMEOUT + 3 || o_err_cnt !== 1) begin
      errors++; $display("FAIL timeout_timing: got done=%0d ready=%0d err=%0d expected done=%0d ready=%0d err=1", o_done, o_ready, o_err_cnt, TIMEOUT + 2, TIMEOUT + 3);
    end
    checks++;
    if (o_lv_cnt !== 1 || o_load_done !== exp_load) begin
      errors++; $display("FAIL timeout_data: got lv=%0d load_in=%h expected lv=1 load_in=%h", o_lv_cnt, o_load_done, exp_load);
    end
`else
    run_txn(1'b0, 8'h09, 16'h0000, 30, 16'hC0DE, 1'b0);
    exp_load = 16'hC0DE;
    checks++;
    if (o_done !== 32 || o_ready !== 33 || o_err_cnt !== 0 || o_en_cnt !== 1) begin
      errors++; $display("FAIL no_timeout_wait: got done=%0d ready=%0d err=%0d strobes=%0d expected done=32 ready=33 err=0 strobes=1", o_done, o_ready, o_err_cnt, o_en_cnt);
    end
    checks++;
    if (Load_in !== exp_load) begin
      errors++; $display("FAIL no_timeout_data: got %h expected %h", Load_in, exp_load);
    end
`endif
  endtask

  task automatic test_random();
    logic              we, stray;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata, rdata;
    int                waits;
    for (int n = 0; n < 12; n++) begin
      we    = 1'($urandom_range(0, 1));
      stray = 1'($urandom_range(0, 1));
      addr  = ADDR_W'($urandom);
      wdata = DATA_W'($urandom);
      rdata = DATA_W'($urandom);
      waits = int'($urandom_range(0, 4));
      run_txn(we, addr, wdata, waits, rdata, stray);
      if (!we) exp_load = rdata;
      checks++;
      if (o_en_cnt !== 1 || o_en_addr !== addr || o_en_we !== we || (we && o_en_wdata !== wdata)) begin
        errors++; $display("FAIL rand%0d_bus: got n=%0d we=%b addr=%h wdata=%h expected n=1 we=%b addr=%h wdata=%h", n, o_en_cnt, o_en_we, o_en_addr, o_en_wdata, we, addr, wdata);
      end
      checks++;
      if (o_done !== 2 + waits || o_ready !== 3 + waits || o_done_cnt !== 1 || o_err_cnt !== 0) begin
        errors++; $display("FAIL rand%0d_timing: got done=%0d x%0d ready=%0d err=%0d expected done=%0d x1 ready=%0d err=0", n, o_done, o_done_cnt, o_ready, o_err_cnt, 2 + waits, 3 + waits);
      end
      checks++;
      if (o_lv_cnt !== int'(!we) || Load_in !== exp_load) begin
        errors++; $display("FAIL rand%0d_load: got lv=%0d load_in=%h expected lv=%0d load_in=%h", n, o_lv_cnt, Load_in, int'(!we), exp_load);
      end
    end
  endtask

  initial begin
    test_reset();
    test_store_zero_wait();
    test_load_wait3();
    test_reset_mid_wait();
    test_busy();
    test_stray_ack();
    test_timeout();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
